// File: rtl/trace_monitor.sv
// trace_monitor
//   Samples a set of watched registers every clock, flags which ones changed,
//   and records timestamped entries into a circular buffer. The buffer drains
//   through a show-ahead valid/ready port.
//
// Ports
//   clk        sole clock, rising edge
//   reset_n    asynchronous active-low reset
//   enable     capture enable
//   mode       0/3 any-change, 1 every-cycle, 2 channel-0-change only
//   chan_mask  per-channel participation in change detection
//   watch      flattened watched values, channel k at [k*WIDTH +: WIDTH]
//   rd_valid   buffer non-empty
//   rd_ready   consumer accepts the head entry
//   rd_data    head entry {timestamp, change_mask, snapshot}, zero when empty
//   count      current occupancy
//   full       count == DEPTH
//   dropped    saturating count of lost (dropped or overwritten) entries
module trace_monitor #(
  parameter int WIDTH        = 8,
  parameter int CHANNELS     = 6,
  parameter int DEPTH        = 16,
  parameter int TS_WIDTH     = 16,
  parameter int DROP_ON_FULL = 0
) (
  input  logic                                    clk,
  input  logic                                    reset_n,
  input  logic                                    enable,
  input  logic [1:0]                              mode,
  input  logic [CHANNELS-1:0]                     chan_mask,
  input  logic [CHANNELS*WIDTH-1:0]               watch,
  output logic                                    rd_valid,
  input  logic                                    rd_ready,
  output logic [TS_WIDTH+CHANNELS+CHANNELS*WIDTH-1:0] rd_data,
  output logic [$clog2(DEPTH):0]                  count,
  output logic                                    full,
  output logic [7:0]                              dropped
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int EW = TS_WIDTH + CHANNELS + CHANNELS * WIDTH;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam bit OVERWRITE = (DROP_ON_FULL == 0);

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic [TS_WIDTH-1:0]        r_tick;
  logic [CHANNELS*WIDTH-1:0]  r_prev;
  logic                       r_prev_valid;
  logic [EW-1:0]              r_mem [DEPTH];
  logic [PW-1:0]              r_wptr;
  logic [PW-1:0]              r_rptr;
  logic [CW-1:0]              r_count;
  logic [7:0]                 r_dropped;

  logic [CHANNELS-1:0]        w_chg;
  logic                       w_event;
  logic                       w_full;
  logic                       w_empty;
  logic                       w_pop;
  logic                       w_loss;
  logic                       w_write;
  logic                       w_adv_rd;
  logic                       w_inc;
  logic                       w_dec;

  // Until a previous sample exists every participating channel counts as changed.
  always_comb begin
    w_chg = chan_mask;
    if (r_prev_valid) begin
      for (int k = 0; k < CHANNELS; k++) begin
        w_chg[k] = (watch[k*WIDTH +: WIDTH] != r_prev[k*WIDTH +: WIDTH]) && chan_mask[k];
      end
    end
  end

  always_comb begin
    w_event = 1'b0;
    if (enable) begin
      case (mode)
        2'd1:    w_event = 1'b1;
        2'd2:    w_event = w_chg[0];
        default: w_event = |w_chg;
      endcase
    end
  end

  assign w_full  = (r_count == FULL_CNT);
  assign w_empty = (r_count == '0);
  assign w_pop   = !w_empty && rd_ready;

  // A push into a full buffer is only a loss when no pop frees a slot this cycle.
  assign w_loss   = w_event && w_full && !w_pop;
  assign w_write  = w_event && (!w_loss || OVERWRITE);
  // On overwrite the write slot is the head slot, so the head moves on with it.
  assign w_adv_rd = w_pop || (w_loss && OVERWRITE);
  assign w_inc    = w_write && !w_pop && !w_full;
  assign w_dec    = w_pop && !w_write;

  // Capture stage: control state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tick       <= '0;
      r_prev       <= '0;
      r_prev_valid <= 1'b0;
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_count      <= '0;
      r_dropped    <= '0;
    end else begin
      r_tick       <= r_tick + TS_WIDTH'(1);
      r_prev       <= watch;
      r_prev_valid <= 1'b1;
      if (w_write) begin
        r_wptr <= r_wptr + PW'(1);
      end
      if (w_adv_rd) begin
        r_rptr <= r_rptr + PW'(1);
      end
      if (w_inc) begin
        r_count <= r_count + CW'(1);
      end else if (w_dec) begin
        r_count <= r_count - CW'(1);
      end
      if (w_loss) begin
        r_dropped <= sat_inc8(r_dropped);
      end
    end
  end

  // Capture stage: entry storage (stale contents are hidden by the empty check)
  always_ff @(posedge clk) begin
    if (w_write) begin
      r_mem[r_wptr] <= {r_tick, w_chg, watch};
    end
  end

  assign rd_valid = !w_empty;
  assign rd_data  = w_empty ? '0 : r_mem[r_rptr];
  assign count    = r_count;
  assign full     = w_full;
  assign dropped  = r_dropped;

endmodule

// File: tb/tb_trace_monitor.sv
module tb_trace_monitor;

  localparam int W   = 8;
  localparam int CH  = 6;
  localparam int D   = 4;
  localparam int TSW = 8;
  localparam int EW  = TSW + CH + CH * W;

  typedef logic [EW-1:0] entry_t;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            enable;
  logic [1:0]      mode;
  logic [CH-1:0]   chan_mask;
  logic [CH*W-1:0] watch;
  logic            rd_ready;

  logic            o_v,    d_v;
  entry_t          o_data, d_data;
  logic [2:0]      o_cnt,  d_cnt;
  logic            o_full, d_full;
  logic [7:0]      o_drop, d_drop;

  trace_monitor #(.WIDTH(W), .CHANNELS(CH), .DEPTH(D), .TS_WIDTH(TSW), .DROP_ON_FULL(0)) u_ovr (
    .clk(clk), .reset_n(reset_n), .enable(enable), .mode(mode), .chan_mask(chan_mask),
    .watch(watch), .rd_valid(o_v), .rd_ready(rd_ready), .rd_data(o_data),
    .count(o_cnt), .full(o_full), .dropped(o_drop)
  );

  trace_monitor #(.WIDTH(W), .CHANNELS(CH), .DEPTH(D), .TS_WIDTH(TSW), .DROP_ON_FULL(1)) u_drp (
    .clk(clk), .reset_n(reset_n), .enable(enable), .mode(mode), .chan_mask(chan_mask),
    .watch(watch), .rd_valid(d_v), .rd_ready(rd_ready), .rd_data(d_data),
    .count(d_cnt), .full(d_full), .dropped(d_drop)
  );

  always #5 clk = ~clk;

  // Reference model: a queue per buffer policy plus the sampling history.
  entry_t          q_o[$];
  entry_t          q_d[$];
  int              drop_o, drop_d;
  logic [TSW-1:0]  m_tick;
  logic [CH*W-1:0] m_prev;
  bit              m_pv;
  int              n_checks = 0;
  int              n_errors = 0;
  logic [TSW-1:0]  cap [6];
  logic [TSW-1:0]  t_save;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q_o.delete();
    q_d.delete();
    drop_o = 0;
    drop_d = 0;
    m_tick = '0;
    m_prev = '0;
    m_pv   = 1'b0;
  endtask

  task automatic check_all();
    check("ovr_valid", o_v,    q_o.size() > 0);
    check("ovr_count", o_cnt,  q_o.size());
    check("ovr_full",  o_full, q_o.size() == D);
    check("ovr_drop",  o_drop, drop_o);
    check("ovr_data",  o_data, (q_o.size() > 0) ? q_o[0] : entry_t'(0));
    check("drp_valid", d_v,    q_d.size() > 0);
    check("drp_count", d_cnt,  q_d.size());
    check("drp_full",  d_full, q_d.size() == D);
    check("drp_drop",  d_drop, drop_d);
    check("drp_data",  d_data, (q_d.size() > 0) ? q_d[0] : entry_t'(0));
  endtask

  // Drive one cycle of inputs, advance the model, clock, then compare.
  task automatic step(input bit en, input logic [1:0] md, input logic [CH-1:0] msk,
                      input logic [CH*W-1:0] w, input bit rdy);
    logic [CH-1:0] chg;
    bit            ev;
    entry_t        e;
    enable    = en;
    mode      = md;
    chan_mask = msk;
    watch     = w;
    rd_ready  = rdy;
    for (int k = 0; k < CH; k++) begin
      chg[k] = m_pv ? ((w[k*W +: W] != m_prev[k*W +: W]) && msk[k]) : msk[k];
    end
    if (!en)           ev = 1'b0;
    else if (md == 1)  ev = 1'b1;
    else if (md == 2)  ev = chg[0];
    else               ev = |chg;
    e = {m_tick, chg, w};
    if (q_o.size() > 0 && rdy) void'(q_o.pop_front());
    if (q_d.size() > 0 && rdy) void'(q_d.pop_front());
    if (ev) begin
      if (q_o.size() < D) q_o.push_back(e);
      else begin
        void'(q_o.pop_front());
        q_o.push_back(e);
        if (drop_o < 255) drop_o++;
      end
      if (q_d.size() < D) q_d.push_back(e);
      else if (drop_d < 255) drop_d++;
    end
    m_tick = m_tick + 1'b1;
    m_prev = w;
    m_pv   = 1'b1;
    @(posedge clk);
    #1;
    check_all();
  endtask

  logic [CH*W-1:0] w0, w1, w2, w3, wr;

  initial begin
    w0 = {8'h60, 8'h50, 8'h12, 8'h30, 8'h20, 8'h10};
    w1 = {8'h60, 8'h50, 8'h34, 8'h30, 8'h20, 8'h10};
    w2 = {8'h60, 8'h50, 8'h34, 8'h30, 8'h21, 8'h10};
    w3 = {8'h60, 8'h50, 8'h34, 8'h30, 8'h21, 8'h05};
    reset_n = 1'b0; enable = 1'b0; mode = 2'd0; chan_mask = '0; watch = w0; rd_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", o_v, 1'b0);
    check("rst_count", o_cnt, 3'd0);
    check("rst_full",  o_full, 1'b0);
    check("rst_drop",  o_drop, 8'd0);
    check("rst_data",  o_data, entry_t'(0));
    @(negedge clk);
    reset_n = 1'b1;

    // Constant watch: one entry with all channels flagged, then nothing more.
    step(1, 2'd0, 6'h3F, w0, 0);
    check("setup_ts",   o_data[EW-1 -: TSW], 8'd0);
    check("setup_mask", o_data[CH*W +: CH], 6'h3F);
    repeat (3) step(1, 2'd0, 6'h3F, w0, 0);
    check("setup_count", o_cnt, 3'd1);
    step(0, 2'd0, 6'h3F, w0, 1);

    // Channel 3 toggle at the sixth edge (tick 5).
    step(1, 2'd0, 6'h3F, w1, 0);
    check("ch3_count", o_cnt, 3'd1);
    check("ch3_mask",  o_data[CH*W +: CH], 6'b001000);
    check("ch3_snap",  o_data[3*W +: W], 8'h34);
    check("ch3_ts",    o_data[EW-1 -: TSW], 8'd5);
    step(0, 2'd0, 6'h3F, w1, 1);

    // Mode 2: channel 1 change ignored, channel 0 change recorded.
    step(1, 2'd2, 6'h3F, w2, 0);
    check("m2_ch1_count", o_cnt, 3'd0);
    step(1, 2'd2, 6'h3F, w3, 0);
    check("m2_ch0_count", o_cnt, 3'd1);
    check("m2_ch0_mask",  o_data[CH*W +: CH], 6'h01);
    step(0, 2'd2, 6'h3F, w3, 1);

    // Mode 1 for six cycles into a depth-4 buffer with no reads.
    for (int i = 0; i < 6; i++) begin
      cap[i] = m_tick;
      step(1, 2'd1, 6'h3F, w3, 0);
    end
    check("ovr_fill_count", o_cnt, 3'd4);
    check("ovr_fill_full",  o_full, 1'b1);
    check("ovr_fill_drop",  o_drop, 8'd2);
    check("ovr_fill_head",  o_data[EW-1 -: TSW], cap[2]);
    check("drp_fill_head",  d_data[EW-1 -: TSW], cap[0]);

    // Drop policy: push with pop while full, then push without pop.
    check("drp_pop_oldest", d_data[EW-1 -: TSW], cap[0]);
    step(1, 2'd1, 6'h3F, w3, 1);
    check("drp_pp_count", d_cnt, 3'd4);
    check("drp_pp_drop",  d_drop, 8'd2);
    check("drp_pp_head",  d_data[EW-1 -: TSW], cap[1]);
    step(1, 2'd1, 6'h3F, w3, 0);
    check("drp_loss_drop", d_drop, 8'd3);

    // Mid-stream asynchronous reset with three entries held.
    step(0, 2'd1, 6'h3F, w3, 1);
    check("pre_rst_count", o_cnt, 3'd3);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_ovr_valid", o_v, 1'b0);
    check("arst_ovr_count", o_cnt, 3'd0);
    check("arst_ovr_drop",  o_drop, 8'd0);
    check("arst_drp_valid", d_v, 1'b0);
    check("arst_drp_count", d_cnt, 3'd0);
    check("arst_drp_drop",  d_drop, 8'd0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    step(1, 2'd0, 6'h2D, w3, 0);
    check("post_rst_mask", o_data[CH*W +: CH], 6'h2D);
    check("post_rst_ts",   o_data[EW-1 -: TSW], 8'd0);

    // Randomized traffic; long enough for the timestamp to wrap.
    wr = w3;
    for (int n = 0; n < 400; n++) begin
      for (int k = 0; k < CH; k++) begin
        if ($urandom_range(3) == 0) wr[k*W +: W] = 8'($urandom);
      end
      step($urandom_range(4) != 0, 2'($urandom_range(3)), 6'($urandom), wr, $urandom_range(1) == 1);
    end

    // Sustained overflow drives the loss counters into saturation.
    for (int n = 0; n < 300; n++) begin
      wr[7:0] = 8'($urandom);
      step(1, 2'd1, 6'h3F, wr, 0);
    end
    check("ovr_sat", o_drop, 8'd255);
    check("drp_sat", d_drop, 8'd255);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/trace_monitor.md
# trace_monitor

Synthesizable, parametrised trace-capture block for the nic8 datapath. It samples a configurable set of watched registers every clock, detects which ones changed, and records timestamped entries into an on-chip circular buffer. A valid/ready port drains the buffer, so register and output-port activity stays visible on hardware without a simulator console.

## Interface
Parameters:
- WIDTH, 8, bits per watched channel
- CHANNELS, 6, number of watched channels (channel 0 is the primary/output channel)
- DEPTH, 16, buffer entries; power of two, at least 2
- TS_WIDTH, 16, timestamp counter width
- DROP_ON_FULL, 0, full policy: 0 overwrites the oldest entry, 1 drops the new entry

Ports:
- clk  in  1  sole clock; everything samples on the rising edge
- reset_n  in  1  asynchronous, active-low reset
- enable  in  1  capture enable
- mode  in  2  capture mode: 0 any-change, 1 every-cycle, 2 channel-0-change only, 3 reserved (treated as 0)
- chan_mask  in  CHANNELS  per-channel participation in change detection
- watch  in  CHANNELS*WIDTH  flattened watched values; channel k is bits [k*WIDTH +: WIDTH]
- rd_valid  out  1  buffer non-empty
- rd_ready  in  1  consumer accepts the head entry
- rd_data  out  TS_WIDTH+CHANNELS+CHANNELS*WIDTH  head entry as {timestamp, change_mask, snapshot}
- count  out  $clog2(DEPTH)+1  current occupancy
- full  out  1  count == DEPTH
- dropped  out  8  saturating count of lost entries (dropped or overwritten)

## Operation
- tick: a TS_WIDTH counter that increments on every clk edge, independent of enable, and wraps modulo 2^TS_WIDTH.
- prev: a snapshot of watch updated on every edge. prev_valid is cleared by reset and set on the first edge after reset.
- Change vector: chg[k] = (watch_k != prev_k) & chan_mask[k].
  - If prev_valid = 0, then chg = chan_mask.
- Event condition, evaluated only when enable = 1:
  - mode 0 or 3: event when |chg is true.
  - mode 1: event on every cycle.
  - mode 2: event when chg[0] is true.
- Entry pushed on an event: {tick at the capturing edge, chg, watch}.
  - In mode 1 the stored change_mask is still chg and may be zero.
- Pop: when rd_valid && rd_ready, the head entry is removed at the edge.
- Full, push with no pop:
  - DROP_ON_FULL = 0: the oldest entry is discarded and the new entry is written. count stays at DEPTH and dropped increments.
  - DROP_ON_FULL = 1: the new entry is discarded. Buffer contents are unchanged and dropped increments.
- Full, push and pop in the same cycle: both happen and count stays at DEPTH. This is not a loss, so dropped does not change.
- Empty, push and pop in the same cycle: no pop occurs, because rd_valid is 0. The push lands and count becomes 1.
- dropped saturates at 255.
- Read and write pointers wrap modulo DEPTH. count distinguishes full from empty.
- Reset values (asynchronous, while reset_n = 0):
  - tick = 0, prev = 0, prev_valid = 0
  - pointers = 0, count = 0, rd_valid = 0, full = 0, dropped = 0
  - rd_data = 0, because empty storage reads as zero
- Reset asserted mid-operation immediately empties the buffer and discards all entries. Entries are not drained.

## Timing
- watch, enable, mode, chan_mask and rd_ready are sampled at the rising edge.
- A change present at edge N is compared against the value sampled at edge N-1.
- Latency: an event captured at edge N makes rd_valid = 1 after edge N, with rd_data showing that entry if the buffer was empty.
  - The stored timestamp equals the tick value present before edge N increments it.
- rd_data is show-ahead. It is stable while rd_valid = 1 and rd_ready = 0, except when DROP_ON_FULL = 0 and a push overwrites the head, in which case the head advances to the next-oldest entry.
- Throughput: one push and one pop per cycle.
- count, full and dropped update at the edge where the push or pop takes effect.
- Changes to enable and mode take effect at the same edge they are sampled.

## Test plan
- Setup: reset, then hold watch constant, mode = 0, chan_mask = all ones, enable = 1.
  - Required: exactly one entry, with change_mask = 6'b111111 and the timestamp of the first enabled edge. No further entries.
- mode 0, toggle channel 3 from 8'h12 to 8'h34 at one edge.
  - Required: one new entry with change_mask = 6'b001000, snapshot channel 3 = 8'h34, and a timestamp one greater than the previous edge's tick.
- mode 2, change channel 1 and then channel 0 (8'h05) on separate cycles.
  - Required: only the channel-0 change is recorded; its entry has change_mask bit 0 set.
- DEPTH = 4, DROP_ON_FULL = 0, mode 1 for 6 cycles with rd_ready = 0.
  - Required: count = 4, full = 1, dropped = 2. The head timestamp is the third capture.
- DROP_ON_FULL = 1, buffer full, push together with rd_ready = 1.
  - Required: count stays at 4, dropped unchanged, and the popped entry is the oldest.
  - Next, push with rd_ready = 0: dropped increments by 1.
- Assert reset_n = 0 mid-stream between edges with the buffer holding 3 entries.
  - Required: rd_valid, count and dropped all read 0 immediately, with no clock edge.
  - After release, the first enabled edge records change_mask = chan_mask.
